// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter between the MEM stage and the debug port.
package PipelineBufferRegisters;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    localparam logic [2:0] DBG_FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM-stage core accesses win; debug gets idle cycles or, with
// DMEM_ARB_STARVE_GUARD_EN defined, a forced one-cycle slot after MAX_WAIT blocked cycles.
module dmem_arbiter
    import PipelineBufferRegisters::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int MEM_ADDRESS_WIDTH = 9,
    parameter int MAX_WAIT          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         core_rd,
    input  logic                         core_wr,
    input  logic [MEM_ADDRESS_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]        core_wdata,
    input  logic [2:0]                   core_funct3,
    output logic [DATA_WIDTH-1:0]        core_rdata,
    output logic                         core_stall,
    input  logic                         dbg_req,
    input  logic                         dbg_we,
    input  logic [MEM_ADDRESS_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]        dbg_wdata,
    output logic                         dbg_ready,
    output logic                         dbg_rvalid,
    output logic [DATA_WIDTH-1:0]        dbg_rdata,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [MEM_ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [2:0]                   mem_funct3,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(MAX_WAIT - 1);
`endif

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
    logic                  core_active;
    logic                  force_slot;
    logic                  dbg_accept;

    always_comb begin
        core_active = core_rd | core_wr;
        force_slot  = (state_q == FORCE);
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_accept  = 1'b0;

        if (force_slot) begin
            // dbg_req is held while pending, so this accepts the starved request
            dbg_accept = dbg_req;
            state_d    = IDLE;
            wait_cnt_d = '0;
        end else if (core_active) begin
            if (dbg_req) begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
                state_d = (wait_cnt_q == CNT_FORCE) ? FORCE : WAIT;
`else
                state_d = WAIT;
`endif
                wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end else begin
                // also covers a request withdrawn while waiting
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        end else begin
            dbg_accept = dbg_req;
            state_d    = IDLE;
            wait_cnt_d = '0;
        end
    end

    always_comb begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_funct3 = core_funct3;
        mem_wr     = core_wr;
        mem_rd     = core_rd & ~core_wr;
        if (dbg_accept) begin
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_funct3 = DBG_FUNCT3_WORD;
            mem_rd     = ~dbg_we;
            mem_wr     = dbg_we;
        end else if (force_slot) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
        // reset must silence the memory and handshake immediately, not at the next edge
        if (!rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    always_comb begin
        dbg_ready    = dbg_accept & rst;
        dbg_rvalid_d = dbg_accept & ~dbg_we;
        dbg_rdata_d  = (dbg_accept & ~dbg_we) ? mem_rdata : dbg_rdata_q;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        core_stall = force_slot & rst;
`else
        core_stall = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int MW = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_funct3;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ready, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem     [0:127];
    logic [DW-1:0] ref_mem [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .MEM_ADDRESS_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    // Word-addressed data memory with combinational read
    assign mem_rdata = mem[mem_addr[AW-1:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[AW-1:2]] <= mem_wdata;

    task automatic all_idle();
        core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0; core_funct3 = 3'b010;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic test_reset();
        all_idle();
        rst = 1'b0;
        core_wr = 1'b1; core_addr = 9'h004; core_wdata = 32'h1234_5678;
        dbg_req = 1'b1; dbg_we = 1'b1;
        #12;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); else n_pass++;
        n_checks++; if (dbg_ready !== 1'b0) $display("FAIL reset_dbg_ready got=%b exp=0", dbg_ready); else n_pass++;
        n_checks++; if (core_stall !== 1'b0) $display("FAIL reset_core_stall got=%b exp=0", core_stall); else n_pass++;
        n_checks++; if (dbg_rvalid !== 1'b0) $display("FAIL reset_dbg_rvalid got=%b exp=0", dbg_rvalid); else n_pass++;
        n_checks++; if (dbg_rdata !== '0) $display("FAIL reset_dbg_rdata got=%h exp=0", dbg_rdata); else n_pass++;
        all_idle();
        @(negedge clk);
        rst = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_dbg_read_idle();
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        @(negedge clk);
        all_idle();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
        #1;
        n_checks++; if (dbg_ready !== 1'b1) $display("FAIL rd_idle_ready got=%b exp=1", dbg_ready); else n_pass++;
        n_checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0) $display("FAIL rd_idle_rdwr got=%b%b exp=10", mem_rd, mem_wr); else n_pass++;
        n_checks++; if (mem_addr !== 9'h010) $display("FAIL rd_idle_addr got=%h exp=010", mem_addr); else n_pass++;
        n_checks++; if (mem_funct3 !== 3'b010) $display("FAIL rd_idle_funct3 got=%b exp=010", mem_funct3); else n_pass++;
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        n_checks++; if (dbg_rvalid !== 1'b1) $display("FAIL rd_idle_rvalid got=%b exp=1", dbg_rvalid); else n_pass++;
        n_checks++; if (dbg_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_idle_rdata got=%h exp=deadbeef", dbg_rdata); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (dbg_rvalid !== 1'b0) $display("FAIL rd_idle_rvalid_pulse got=%b exp=0", dbg_rvalid); else n_pass++;
        $display("dbg_read_idle: addr=010 data=%h", dbg_rdata);
    endtask

    task automatic test_collision();
        @(negedge clk);
        core_wr = 1'b1; core_addr = 9'h020; core_wdata = 32'h55; core_funct3 = 3'b010;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'hAA;
        #1;
        n_checks++; if (dbg_ready !== 1'b0) $display("FAIL coll_ready0 got=%b exp=0", dbg_ready); else n_pass++;
        n_checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'h55) $display("FAIL coll_core_wr got=%b/%h exp=1/55", mem_wr, mem_wdata); else n_pass++;
        n_checks++; if (core_stall !== 1'b0) $display("FAIL coll_stall0 got=%b exp=0", core_stall); else n_pass++;
        @(negedge clk);
        core_wr = 1'b0;
        #1;
        n_checks++; if (dbg_ready !== 1'b1) $display("FAIL coll_ready1 got=%b exp=1", dbg_ready); else n_pass++;
        n_checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== 32'hAA) $display("FAIL coll_dbg_wr got=%b%b/%h exp=10/aa", mem_wr, mem_rd, mem_wdata); else n_pass++;
        n_checks++; if (core_stall !== 1'b0) $display("FAIL coll_stall1 got=%b exp=0", core_stall); else n_pass++;
        @(negedge clk);
        all_idle();
        ref_mem[8] = 32'hAA;
        #1;
        n_checks++; if (mem[8] !== 32'hAA) $display("FAIL coll_final_word got=%h exp=aa", mem[8]); else n_pass++;
        $display("collision: final word=%h", mem[8]);
    endtask

    // Core busy for 20 cycles with a debug read held; model counts consecutive blocked cycles
    task automatic test_starvation();
        int blocked = 0;
        bit accepted = 1'b0;
        bit exp_force, exp_ready, exp_rvalid;
        int acc_cycle = -1;
        int exp_cycle;
        exp_rvalid = 1'b0;
        exp_cycle = GUARD ? MW : 20;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            core_rd = (c < 20); core_wr = 1'b0; core_addr = 9'h004;
            dbg_req = !accepted; dbg_we = 1'b0; dbg_addr = 9'h010;
            #1;
            exp_force = GUARD && (blocked == MW);
            exp_ready = dbg_req && (exp_force || !core_rd);
            n_checks++; if (core_stall !== exp_force) $display("FAIL starve_stall c=%0d got=%b exp=%b", c, core_stall, exp_force); else n_pass++;
            n_checks++; if (dbg_ready !== exp_ready) $display("FAIL starve_ready c=%0d got=%b exp=%b", c, dbg_ready, exp_ready); else n_pass++;
            n_checks++; if (dbg_rvalid !== exp_rvalid) $display("FAIL starve_rvalid c=%0d got=%b exp=%b", c, dbg_rvalid, exp_rvalid); else n_pass++;
            exp_rvalid = exp_ready;
            if (exp_ready) begin accepted = 1'b1; acc_cycle = c; end
            if (exp_ready || exp_force || !dbg_req) blocked = 0;
            else if (core_rd) blocked++;
        end
        n_checks++; if (acc_cycle != exp_cycle) $display("FAIL starve_accept_cycle got=%0d exp=%0d", acc_cycle, exp_cycle); else n_pass++;
        all_idle();
        $display("starvation: debug accepted at cycle %0d", acc_cycle);
    endtask

    // Reset while a debug write is pending (in FORCE when the guard is built in)
    task automatic test_reset_pending();
        int n_block;
        n_block = GUARD ? MW : 3;
        for (int c = 0; c < n_block; c++) begin
            @(negedge clk);
            core_wr = 1'b1; core_addr = 9'h030; core_wdata = 32'h1111;
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h034; dbg_wdata = 32'h2222;
        end
        @(negedge clk);
        #1;
        n_checks++; if (core_stall !== GUARD) $display("FAIL rstp_pre_stall got=%b exp=%b", core_stall, GUARD); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (core_stall !== 1'b0) $display("FAIL rstp_stall got=%b exp=0", core_stall); else n_pass++;
        n_checks++; if (dbg_ready !== 1'b0) $display("FAIL rstp_ready got=%b exp=0", dbg_ready); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL rstp_mem_wr got=%b exp=0", mem_wr); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        // still blocked after release: no carried-over force slot
        n_checks++; if (core_stall !== 1'b0 || dbg_ready !== 1'b0) $display("FAIL rstp_after got=%b%b exp=00", core_stall, dbg_ready); else n_pass++;
        ref_mem[12] = 32'h1111;
        @(negedge clk);
        all_idle();
        #1;
        n_checks++; if (mem[13] !== ref_mem[13]) $display("FAIL rstp_no_dbg_write got=%h exp=%h", mem[13], ref_mem[13]); else n_pass++;
        $display("reset_pending: discarded debug write");
    endtask

    task automatic test_random();
        int blocked = 0;
        bit acc_prev = 1'b0;
        bit exp_rvalid = 1'b0;
        logic [DW-1:0] exp_rdata = '0;
        bit exp_force, exp_ready, exp_rd, exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        int sel;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sel = $urandom_range(0, 9);
            core_rd = (sel < 4); core_wr = (sel >= 4 && sel < 7);
            core_addr = {7'($urandom_range(0, 127)), 2'b00};
            core_wdata = $urandom; core_funct3 = 3'($urandom_range(0, 7));
            if (acc_prev) dbg_req = 1'b0;
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = {7'($urandom_range(0, 127)), 2'b00}; dbg_wdata = $urandom;
            end
            #1;
            exp_force = GUARD && (blocked == MW);
            exp_ready = dbg_req && (exp_force || !(core_rd || core_wr));
            if (exp_ready) begin
                exp_rd = !dbg_we; exp_wr = dbg_we; exp_addr = dbg_addr; exp_wdata = dbg_wdata;
            end else if (exp_force) begin
                exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = core_addr; exp_wdata = core_wdata;
            end else begin
                exp_rd = core_rd; exp_wr = core_wr; exp_addr = core_addr; exp_wdata = core_wdata;
            end
            n_checks++; if (core_stall !== exp_force) $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, core_stall, exp_force); else n_pass++;
            n_checks++; if (dbg_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, dbg_ready, exp_ready); else n_pass++;
            n_checks++; if (mem_rd !== exp_rd || mem_wr !== exp_wr) $display("FAIL rnd_rdwr c=%0d got=%b%b exp=%b%b", c, mem_rd, mem_wr, exp_rd, exp_wr); else n_pass++;
            if (exp_rd || exp_wr) begin
                n_checks++; if (mem_addr !== exp_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr); else n_pass++;
            end
            if (exp_wr) begin
                n_checks++; if (mem_wdata !== exp_wdata) $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, exp_wdata); else n_pass++;
            end
            if (exp_ready) begin
                n_checks++; if (mem_funct3 !== 3'b010) $display("FAIL rnd_funct3 c=%0d got=%b exp=010", c, mem_funct3); else n_pass++;
            end
            if (exp_rd && !exp_ready) begin
                n_checks++; if (core_rdata !== ref_mem[exp_addr[AW-1:2]]) $display("FAIL rnd_core_rdata c=%0d got=%h exp=%h", c, core_rdata, ref_mem[exp_addr[AW-1:2]]); else n_pass++;
            end
            n_checks++; if (dbg_rvalid !== exp_rvalid) $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, dbg_rvalid, exp_rvalid); else n_pass++;
            if (exp_rvalid) begin
                n_checks++; if (dbg_rdata !== exp_rdata) $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, dbg_rdata, exp_rdata); else n_pass++;
            end
            if (exp_ready)
                $display("random: c=%0d dbg %s addr=%h force=%b", c, dbg_we ? "wr" : "rd", dbg_addr, exp_force);
            exp_rvalid = exp_ready && !dbg_we;
            if (exp_rvalid) exp_rdata = ref_mem[dbg_addr[AW-1:2]];
            if (exp_wr) ref_mem[exp_addr[AW-1:2]] = exp_wdata;
            acc_prev = exp_ready;
            if (exp_ready || exp_force || !dbg_req) blocked = 0;
            else blocked++;
        end
        @(negedge clk);
        all_idle();
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            n_checks++; if (mem[i] !== ref_mem[i]) $display("FAIL rnd_final_mem idx=%0d got=%h exp=%h", i, mem[i], ref_mem[i]); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_dbg_read_idle();
        test_collision();
        test_starvation();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 32, data bus width.
- MEM_ADDRESS_WIDTH, 9, data-memory byte address width.
- MAX_WAIT, 8, debug wait cycles before a forced slot.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- core_rd, in, 1, MEM-stage read request.
- core_wr, in, 1, MEM-stage write request.
- core_addr, in, MEM_ADDRESS_WIDTH, MEM-stage address.
- core_wdata, in, DATA_WIDTH, MEM-stage store data.
- core_funct3, in, 3, MEM-stage access size/sign.
- core_rdata, out, DATA_WIDTH, load data to MEM/WB.
- core_stall, out, 1, freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle.
- dbg_req, in, 1, debug access valid; held until accepted.
- dbg_we, in, 1, debug write (1) / read (0).
- dbg_addr, in, MEM_ADDRESS_WIDTH, debug address.
- dbg_wdata, in, DATA_WIDTH, debug write data.
- dbg_ready, out, 1, debug access accepted this cycle.
- dbg_rvalid, out, 1, debug read data valid (one-cycle pulse).
- dbg_rdata, out, DATA_WIDTH, debug read data.
- mem_rd, out, 1, DataMemory read enable.
- mem_wr, out, 1, DataMemory write enable.
- mem_addr, out, MEM_ADDRESS_WIDTH, DataMemory address.
- mem_wdata, out, DATA_WIDTH, DataMemory write data.
- mem_funct3, out, 3, DataMemory size/sign.
- mem_rdata, in, DATA_WIDTH, DataMemory combinational read data.

Function
REQ-003 Core is active when core_rd|core_wr; core has priority over debug in every non-FORCE cycle.
REQ-004 FSM has three states:
- IDLE: no debug request pending.
- WAIT: debug request blocked by the core.
- FORCE: forced debug slot.
REQ-005 IDLE/WAIT, core inactive and dbg_req=1: dbg_ready=1 the same cycle; mem_* driven from dbg_*; next state IDLE.
REQ-006 IDLE/WAIT, core active: mem_* driven from core_*; dbg_ready=0; if dbg_req=1, next state WAIT and wait_cnt increments.
REQ-007 A blocked cycle with wait_cnt=MAX_WAIT-1 transitions to FORCE instead of WAIT.
REQ-008 FORCE, exactly one cycle:
- core_stall=1, dbg_ready=1, mem_* driven from dbg_*.
- next state IDLE, wait_cnt cleared.
REQ-009 core_stall=0 in every state other than FORCE.
REQ-010 Debug accesses use mem_funct3=3'b010 (word); mem_rd=~dbg_we, mem_wr=dbg_we.
REQ-011 Debug read: dbg_rdata registers mem_rdata on the accepting edge; dbg_rvalid=1 for exactly the following cycle.
REQ-012 core_rdata=mem_rdata combinationally; its value is don't-care in FORCE cycles.
REQ-013 wait_cnt is $clog2(MAX_WAIT+1) bits and saturates at MAX_WAIT; it clears on any debug acceptance.
REQ-014 dbg_req dropping in WAIT (protocol violation): next state IDLE, wait_cnt cleared, no access issued.
REQ-015 No cycle issues mem_rd and mem_wr together; with no requester active, mem_rd=mem_wr=0.

Reset
REQ-016 rst=0 asynchronously forces:
- state IDLE, wait_cnt=0.
- dbg_ready=0, dbg_rvalid=0, dbg_rdata=0.
- core_stall=0, mem_rd=0, mem_wr=0.
REQ-017 Reset mid-FORCE or mid-WAIT discards the pending debug access; no memory write occurs while rst=0.

Configuration
REQ-018 Macro DMEM_ARB_STARVE_GUARD_EN:
- Defined: FORCE state and REQ-007/008 are active.
- Undefined: FORCE is absent, core_stall is tied 0, and debug is served only in core-idle cycles (WAIT indefinitely).

Structure
REQ-019 Shared package PipelineBufferRegisters carries:
- arb_state_t enum (IDLE, WAIT, FORCE).
- constant DBG_FUNCT3_WORD=3'b010.
REQ-020 No sub-module; the wait counter and FSM are inline. DataPath instantiates dmem_arbiter between the EX/MEM register and DataMemory.

Verification
REQ-021 Core idle, dbg read addr 0x010 (mem holds 0xDEADBEEF) -> dbg_ready same cycle; dbg_rvalid next cycle with dbg_rdata=0xDEADBEEF.
REQ-022 Core write 0x55 to 0x020 while dbg write 0xAA to 0x020, core goes idle next cycle -> core write first, debug write next cycle; final word 0xAA; core_stall never 1.
REQ-023 Core active continuously, dbg_req held, MAX_WAIT=8 -> state WAIT for cycles 1-7, FORCE on cycle 8 with core_stall=1 for exactly 1 cycle, then IDLE.
REQ-024 Assert rst=0 in FORCE cycle -> core_stall=0, dbg_ready=0 immediately; no mem_wr; state IDLE after release.
REQ-025 Build without DMEM_ARB_STARVE_GUARD_EN, core active for 20 cycles -> core_stall=0 throughout; debug accepted on first core-idle cycle.
